// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared widths, constants, FSM state and buffer entry type for
//            the instruction-fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;

   localparam logic [XLEN-1:0]    PC_STEP   = 32'd4;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Synchronous FIFO with flush; head is registered storage (no
//            bypass) and reads as zero while empty.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             empty, full, do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop_i && !empty;
   // A full FIFO may accept a push when the head leaves in the same cycle.
   assign do_push = push_i && (!full || do_pop);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + AW'(1);
         if (do_pop)  rptr_d = rptr_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wptr_q] <= push_data_i;
   end

   assign head_o  = empty ? '0 : mem_q[rptr_q];
   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : In-order instruction fetch with credit-limited issue, PC tag
//            queue, fetch buffer and stale-response squash on redirect.
//            Optional macro FETCH_MISALIGN_CHECK_EN adds fetch_misaligned.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [XLEN-1:0]    pc,
   output logic [XLEN-1:0]    pc_next,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [XLEN-1:0]    imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [XLEN-1:0]    if_pc,
   output logic [INSTR_W-1:0] if_instr
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic               fetch_misaligned
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam logic [CW:0] DEPTH_LIM = FIFO_DEPTH[CW:0];

   fetch_state_e    state_q, state_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   kill_cnt_q, kill_cnt_d;
   logic [CW-1:0]   buf_count;
   logic [CW-1:0]   tag_count_unused;
   logic [CW:0]     inflight;
   logic [XLEN-1:0] tag_head;
   logic [XLEN-1:0] redirect_target;
   fetch_entry_t    buf_push_entry, buf_head;
   logic            credit_ok, accept, rsp_live, buf_pop;

   assign buf_pop  = if_valid && if_ready;
   // The entry leaving the buffer this cycle returns its credit immediately,
   // which sustains one instruction per cycle with a single-cycle memory.
   assign inflight  = {1'b0, outstanding_q} + {1'b0, buf_count} - {{CW{1'b0}}, buf_pop};
   assign credit_ok = (inflight < DEPTH_LIM);

   assign imem_req_valid = rst && (state_q == RUN) && !redirect_valid && credit_ok;
   assign imem_req_addr  = pc;
   assign accept         = imem_req_valid && imem_req_ready;
   assign rsp_live       = imem_rsp_valid && (state_q == RUN) && !redirect_valid;

   assign outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);

`ifdef FETCH_MISALIGN_CHECK_EN
   logic misaligned_q;
   assign redirect_target  = (redirect_pc[1:0] != 2'b00) ? pc : redirect_pc;
   assign fetch_misaligned = misaligned_q;

   always_ff @(posedge clk) begin
      if (!rst) misaligned_q <= 1'b0;
      else      misaligned_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
   end
`else
   logic [1:0] redirect_lsb_unused;
   assign redirect_lsb_unused = redirect_pc[1:0];
   assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
`endif

   always_comb begin
      if (!rst)                pc_next = RESET_PC;
      else if (redirect_valid) pc_next = redirect_target;
      else if (accept)         pc_next = pc + PC_STEP;
      else                     pc_next = pc;
   end

   always_comb begin
      state_d    = state_q;
      kill_cnt_d = kill_cnt_q;
      if (redirect_valid) begin
         // A response landing in the redirect cycle is itself dropped.
         kill_cnt_d = outstanding_q - CW'(imem_rsp_valid);
         state_d    = (kill_cnt_d != '0) ? DRAIN : RUN;
      end else if ((state_q == DRAIN) && imem_rsp_valid) begin
         kill_cnt_d = kill_cnt_q - CW'(1);
         if (kill_cnt_d == '0) state_d = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= RUN;
         outstanding_q <= '0;
         kill_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         outstanding_q <= outstanding_d;
         kill_cnt_q    <= kill_cnt_d;
      end
   end

   fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (FIFO_DEPTH)
   ) u_tag_q (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (redirect_valid),
      .push_i      (accept),
      .push_data_i (pc),
      .pop_i       (rsp_live),
      .head_o      (tag_head),
      .count_o     (tag_count_unused)
   );

   assign buf_push_entry = '{pc: tag_head, instr: imem_rsp_data};

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fetch_buf (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (redirect_valid),
      .push_i      (rsp_live),
      .push_data_i (buf_push_entry),
      .pop_i       (buf_pop),
      .head_o      (buf_head),
      .count_o     (buf_count)
   );

   assign if_valid = (buf_count != '0);
   assign if_pc    = buf_head.pc;
   assign if_instr = buf_head.instr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit: cycle vector table plus
//            redirect/misalign/wrap sequences against a delivery scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid, if_ready;
   logic [31:0] if_pc, if_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        fetch_misaligned;
`endif

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc             (pc),
      .pc_next        (pc_next),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .fetch_misaligned (fetch_misaligned)
`endif
   );

   typedef struct {
      logic [31:0] data;
      int          due;
   } mem_rsp_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   typedef struct {
      logic        rst, ifr, mr, chk;
      logic        ev;
      logic [31:0] eaddr, enext;
      logic        eifv;
      logic [31:0] eifpc;
   } vec_t;

   mem_rsp_t    mem_q[$];
   exp_t        exp_q[$];
   vec_t        vecs[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   int          lat    = 1;
   logic [31:0] model_pc;
   logic [31:0] watch_pc;
   bit          watch_hit;
   logic        s_accept, s_rst;
   logic [31:0] s_pc_next, s_addr;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(negedge clk);
      s_rst = rst;
      if (rst && if_valid && if_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deliver_unexpected: got pc %h, required no delivery (cycle %0d)", if_pc, cyc);
         end else begin
            e = exp_q.pop_front();
            check32("deliver_pc", if_pc, e.pc);
            check32("deliver_instr", if_instr, e.instr);
            if (if_pc == watch_pc) watch_hit = 1'b1;
         end
      end
      s_accept = rst && imem_req_valid && imem_req_ready;
      s_addr   = imem_req_addr;
      if (s_accept) begin
         check32("req_addr", imem_req_addr, model_pc);
         exp_q.push_back('{model_pc, model_pc ^ 32'hA5A5_0000});
         model_pc = model_pc + 32'd4;
      end
      if (rst && redirect_valid) begin
         exp_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
         if (redirect_pc[1:0] == 2'b00) model_pc = redirect_pc;
`else
         model_pc = {redirect_pc[31:2], 2'b00};
`endif
      end
      if (!rst) begin
         exp_q.delete();
         model_pc = 32'h0;
      end
      s_pc_next = pc_next;
      @(posedge clk);
      #1;
      if (s_accept) mem_q.push_back('{s_addr ^ 32'hA5A5_0000, cyc + lat});
      cyc++;
      pc = s_pc_next;
      if (!s_rst) mem_q.delete();
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_q[0].data;
         void'(mem_q.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
   endtask

   task automatic reset_dut(input int latency);
      rst = 1'b0; if_ready = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0;
      tick();
      tick();
      lat = latency; rst = 1'b1; if_ready = 1'b1; imem_req_ready = 1'b1;
      watch_hit = 1'b0;
   endtask

   task automatic pulse_redirect(input logic [31:0] target, input logic [31:0] exp_next);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      #1;
      check32("redirect_req_valid", 32'(imem_req_valid), 32'd0);
      check32("redirect_pc_next", pc_next, exp_next);
      tick();
      redirect_valid = 1'b0;
   endtask

   task automatic add(input logic r, ifr, mr, chk, ev, input logic [31:0] a, n,
                      input logic v, input logic [31:0] p);
      vecs.push_back('{r, ifr, mr, chk, ev, a, n, v, p});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] cur_pc;
      rst = 1'b0; pc = 32'h0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      if_ready = 1'b0; model_pc = 32'h0; watch_pc = 32'hFFFF_FFFF; watch_hit = 1'b0;

      //   rst ifr mr chk ev  addr   pc_next ifv if_pc
      add(0, 0, 0, 1, 0, 32'h00, 32'h00, 0, 32'h00);  // reset held
      add(0, 0, 0, 1, 0, 32'h00, 32'h00, 0, 32'h00);
      add(1, 1, 1, 1, 1, 32'h00, 32'h04, 0, 32'h00);  // first request
      add(1, 1, 1, 1, 1, 32'h04, 32'h08, 0, 32'h00);
      add(1, 1, 1, 1, 1, 32'h08, 32'h0C, 1, 32'h00);  // streaming
      add(1, 1, 1, 1, 1, 32'h0C, 32'h10, 1, 32'h04);
      add(1, 1, 1, 1, 1, 32'h10, 32'h14, 1, 32'h08);
      add(1, 1, 1, 1, 1, 32'h14, 32'h18, 1, 32'h0C);
      add(0, 1, 1, 0, 0, 32'h00, 32'h00, 0, 32'h00);  // mid-run reset
      add(0, 0, 1, 1, 0, 32'h00, 32'h00, 0, 32'h00);
      add(1, 0, 1, 1, 1, 32'h00, 32'h04, 0, 32'h00);  // backpressure
      add(1, 0, 1, 1, 1, 32'h04, 32'h08, 0, 32'h00);
      add(1, 0, 1, 1, 0, 32'h08, 32'h08, 1, 32'h00);
      add(1, 0, 1, 1, 0, 32'h08, 32'h08, 1, 32'h00);
      add(1, 1, 1, 1, 1, 32'h08, 32'h0C, 1, 32'h00);
      add(1, 1, 1, 1, 1, 32'h0C, 32'h10, 1, 32'h04);
      add(1, 1, 0, 1, 1, 32'h10, 32'h10, 1, 32'h08);  // memory stall
      add(1, 1, 0, 1, 1, 32'h10, 32'h10, 1, 32'h0C);
      add(1, 1, 0, 1, 1, 32'h10, 32'h10, 0, 32'h00);
      add(1, 1, 1, 1, 1, 32'h10, 32'h14, 0, 32'h00);
      add(1, 1, 1, 1, 1, 32'h14, 32'h18, 0, 32'h00);
      add(1, 1, 1, 1, 1, 32'h18, 32'h1C, 1, 32'h10);

      @(posedge clk);
      #1;
      foreach (vecs[i]) begin
         rst = vecs[i].rst; if_ready = vecs[i].ifr; imem_req_ready = vecs[i].mr;
         #1;
         if (vecs[i].chk) begin
            check32($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].ev));
            check32($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].eaddr);
            check32($sformatf("v%0d_pc_next", i), pc_next, vecs[i].enext);
            check32($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(vecs[i].eifv));
            check32($sformatf("v%0d_if_pc", i), if_pc, vecs[i].eifpc);
         end
         tick();
      end
      imem_req_ready = 1'b0; if_ready = 1'b1;
      repeat (6) tick();
      check32("drain_no_loss", 32'(exp_q.size()), 32'd0);
      check32("drain_if_valid", 32'(if_valid), 32'd0);

      // Redirect with two requests in flight
      reset_dut(3);
      watch_pc = 32'h100;
      tick();
      tick();
      pulse_redirect(32'h100, 32'h100);
      check32("r2_kill_cnt", 32'(dut.kill_cnt_q), 32'd2);
      check32("r2_state", 32'(dut.state_q), 32'(DRAIN));
      repeat (10) tick();
      check32("r2_resume_0x100", 32'(watch_hit), 32'd1);

      // Redirect coincident with a response
      reset_dut(2);
      watch_pc = 32'h200;
      tick();
      tick();
      check32("rc_rsp_present", 32'(imem_rsp_valid), 32'd1);
      pulse_redirect(32'h200, 32'h200);
      check32("rc_kill_cnt", 32'(dut.kill_cnt_q), 32'd1);
      check32("rc_state", 32'(dut.state_q), 32'(DRAIN));
      repeat (8) tick();
      check32("rc_resume_0x200", 32'(watch_hit), 32'd1);

      // Misaligned redirect alongside a delivery and a response
      reset_dut(1);
      tick();
      tick();
      tick();
      cur_pc = pc;
`ifdef FETCH_MISALIGN_CHECK_EN
      watch_pc = cur_pc;
      pulse_redirect(32'h102, cur_pc);
      check32("mis_flag_high", 32'(fetch_misaligned), 32'd1);
      tick();
      check32("mis_flag_low", 32'(fetch_misaligned), 32'd0);
`else
      watch_pc = 32'h100;
      pulse_redirect(32'h102, 32'h100);
`endif
      check32("mis_kill_cnt", 32'(dut.kill_cnt_q), 32'd0);
      check32("mis_state", 32'(dut.state_q), 32'(RUN));
      repeat (8) tick();
      check32("mis_resume", 32'(watch_hit), 32'd1);

      // PC wrap across the top of the address space
      watch_hit = 1'b0;
      watch_pc  = 32'h0000_0004;
      pulse_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8);
      repeat (12) tick();
      check32("wrap_reaches_4", 32'(watch_hit), 32'd1);

      imem_req_ready = 1'b0;
      repeat (6) tick();
      check32("final_no_loss", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly downstream of `program_counter`. It consumes the registered `pc`, issues in-order instruction-memory requests, buffers returned words in a small FIFO, and delivers `{pc, instr}` pairs to decode over a valid/ready handshake. It also produces `pc_next` for `program_counter`: sequential increment, hold under backpressure, or redirect target from execute. Stale responses are squashed on redirect.

## Interface
- `RESET_PC`, 32'h0000_0000: value driven on `pc_next` while in reset.
- `FIFO_DEPTH`, 2: fetch buffer entries; also the cap on in-flight plus buffered instructions (power of two, ≥2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `pc`  in  32  current PC from `program_counter`.
- `pc_next`  out  32  next PC to `program_counter`.
- `redirect_valid`  in  1  branch/jump taken; one-cycle pulse.
- `redirect_pc`  in  32  redirect target.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  request address, equal to `pc`.
- `imem_rsp_valid`  in  1  response valid. Responses are in order and arrive ≥1 cycle after acceptance; no rsp backpressure.
- `imem_rsp_data`  in  32  instruction word.
- `if_valid`  out  1  FIFO head valid.
- `if_ready`  in  1  decode accepts.
- `if_pc`  out  32  PC of head instruction.
- `if_instr`  out  32  head instruction.

## Operation
- States:
  - RUN: normal issue.
  - DRAIN: drop stale responses; no issue.
- `outstanding` counter, width clog2(FIFO_DEPTH+1): requests accepted but not yet responded.
- Issue condition: RUN, no `redirect_valid`, and `outstanding + occupancy < FIFO_DEPTH`.
  - `imem_req_valid` equals the issue condition (combinational).
  - Accept = `imem_req_valid & imem_req_ready`.
- `pc_next` priority:
  - `rst`=0 gives `RESET_PC`.
  - Else `redirect_valid` gives `redirect_pc`.
  - Else accept gives `pc + 4` (mod 2^32; wraps 0xFFFF_FFFC → 0).
  - Else `pc` (hold).
- Each accept pushes the request address into a PC tag queue of FIFO_DEPTH entries. Each non-stale response pops a tag and pushes `{tag, imem_rsp_data}` into the fetch FIFO. Space is guaranteed by the credit rule.
- Redirect:
  - Fetch FIFO and tag queue are flushed.
  - `kill_cnt` is loaded with `outstanding` (minus 1 if a response arrives in the same cycle, since that response is dropped).
  - Go to DRAIN if the loaded `kill_cnt` > 0, else stay in RUN.
- DRAIN: each `imem_rsp_valid` decrements `kill_cnt` and the data is discarded. At 0, return to RUN. A redirect during DRAIN reloads `kill_cnt` by the same rule.
- FIFO:
  - Push and pop in the same cycle is legal when full or empty-with-push. No bypass: a pushed entry is visible next cycle.
  - The head is held stable while `if_valid & !if_ready`.
  - A redirect in the same cycle as an `if_ready` pop still flushes; the popped entry counts as delivered.

## Timing
- Reset (`rst`=0 at an edge), values after that edge:
  - `if_valid`=0, `imem_req_valid`=0.
  - `outstanding`=0, `kill_cnt`=0, FIFO empty, state RUN.
  - `if_pc`/`if_instr`=0.
- First request: the first cycle with `rst`=1 (`pc` = `RESET_PC`).
- Latency: response at edge N gives `if_valid` high after edge N. With a 1-cycle memory, the first instruction reaches decode 2 cycles after its request.
- Steady-state throughput: 1 instr/cycle with 1-cycle memory and FIFO_DEPTH ≥ 2.
- Reset mid-operation clears all state. Memory is reset together with this block, so no responses are pending afterward.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - Adds output `fetch_misaligned` (1 bit, reset 0).
  - A redirect with `redirect_pc[1:0] != 0` is not taken: `pc_next` = `pc`, flush and DRAIN still occur, and `fetch_misaligned` pulses high for one cycle.
- Undefined:
  - Port absent.
  - `pc_next` on redirect = `{redirect_pc[31:2], 2'b00}`.

## Structure
- `fetch_pkg`:
  - Constants XLEN=32, INSTR_W=32, PC_STEP=4, NOP_INSTR=32'h0000_0013.
  - State enum {RUN, DRAIN}.
- Sub-module `fetch_fifo`: parameterised synchronous FIFO with flush, used for both the fetch buffer (width 64) and the tag queue (width 32).

## Test plan
- Reset: hold `rst`=0 for 2 cycles → `pc_next`=0, `imem_req_valid`=0, `if_valid`=0; first request at addr 0 in the first cycle after release.
- Streaming: `imem_req_ready`=1, 1-cycle responses with data=addr^32'hA5A5_0000, `if_ready`=1 → `if_pc` = 0, 4, 8, 12 on consecutive cycles with matching data.
- Backpressure: `if_ready`=0 → exactly 2 requests (0, 4), then `imem_req_valid`=0 and `pc_next` holds 8. Raise `if_ready` → 0, 4, 8 delivered, no loss or duplication.
- Memory stall: `imem_req_ready`=0 for 3 cycles → `imem_req_addr` and `pc_next` hold, then resume.
- Redirect with 2 in flight to 0x100 → both responses dropped, `if_valid` stays 0 until `if_pc`=0x100. Also cover redirect coincident with a response: that response is dropped and `kill_cnt`=1.
- `FETCH_MISALIGN_CHECK_EN`: redirect to 0x102 → `fetch_misaligned` pulses 1 cycle, `pc_next` = current `pc`. Without the macro, fetch resumes at 0x100.
